// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit seven-segment driver with blink, leading-zero and anti-ghost blanking.
// Latency: seg/an are registered, 1 clk from the live digit inputs and the scan state.
// Backpressure: none; free-running scan, and blink_tick is a single-cycle strobe.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GHOST_CYCLES = 1000,
    parameter int LZ_BLANK     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blink_mask,
    input  logic       blink_tick,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GHOST_END = CW'(GHOST_CYCLES);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    logic [CW-1:0] slot_cnt;
    logic [1:0]    idx;
    logic          blink_phase;

    logic          slot_wrap;
    logic [3:0]    cur_digit;
    logic          in_ghost;
    logic          blink_off;
    logic          lz_off;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign slot_wrap = (slot_cnt == SLOT_LAST);

    always_comb begin
        cur_digit = digit0;
        lz_off    = 1'b0;
        case (idx)
            2'd0: cur_digit = digit0;
            2'd1: cur_digit = digit1;
            2'd2: cur_digit = digit2;
            default: cur_digit = digit3;
        endcase

        // A digit is a leading zero only if it and every digit to its left are zero.
        if (LZ_BLANK != 0) begin
            case (idx)
                2'd1: lz_off = (digit3 == 4'd0) && (digit2 == 4'd0) && (digit1 == 4'd0);
                2'd2: lz_off = (digit3 == 4'd0) && (digit2 == 4'd0);
                2'd3: lz_off = (digit3 == 4'd0);
                default: lz_off = 1'b0;
            endcase
        end

        in_ghost  = (slot_cnt < GHOST_END);
        blink_off = blink_mask[idx] && blink_phase;
        blank     = in_ghost || blink_off || lz_off;

        seg_nxt = decode(cur_digit);
        an_nxt  = ~(4'b0001 << idx);
        if (blank) begin
            seg_nxt = SEG_OFF;
            an_nxt  = AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            idx         <= 2'd0;
            blink_phase <= 1'b0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
        end else begin
            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule
